// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: program counter, instruction-memory fetch and instruction
// register for the multicycle core. One fetch is in flight at a time; the
// fetched word is offered to the controller over a valid/ack handshake.
//
// Handshake: ir_valid is high while ir/pc hold an unconsumed word (state HOLD);
// the word is consumed on a clock edge where ir_valid && ir_ack. ir_ack is
// ignored in every other state. A redirect in HOLD discards the held word and
// takes priority over a simultaneous ir_ack.
//
// Optional feature: define IFU_PERF_CNT_EN to add the saturating stall_cnt and
// fetch_cnt performance counters (ports absent otherwise).
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MEM_LAT  = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_req,
    output logic        ir_valid,
    output logic [31:0] ir,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        ir_ack,
    input  logic        redirect,
    input  logic        redirect_sel,
    input  logic [31:0] redirect_tgt,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
`ifdef IFU_PERF_CNT_EN
    output logic [31:0] stall_cnt,
    output logic [31:0] fetch_cnt,
`endif
    output logic        busy,
    output logic [1:0]  state_dbg
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    localparam logic [3:0] LAT = 4'(MEM_LAT);

    logic [1:0]  state_q, state_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [31:0] next_pc_q, next_pc_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic        latch_word;
    logic [31:0] rel_tgt;
    logic [31:0] abs_tgt;
    logic [31:0] redir_tgt;

    assign pc_plus4  = pc_q + 32'd4;
    assign ir        = ir_q;
    assign pc        = pc_q;
    assign imem_addr = next_pc_q;
    assign ir_valid  = (state_q == S_HOLD);
    assign busy      = (state_q == S_WAIT);
    assign state_dbg = state_q;

    // Branch offset is a signed word count taken from the held instruction;
    // absolute targets are forced to word alignment.
    assign rel_tgt   = pc_plus4 + {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
    assign abs_tgt   = redirect_tgt & ~32'd3;
    assign redir_tgt = redirect_sel ? abs_tgt : rel_tgt;

    // Next-state logic: redirect first, then the normal fetch sequence.
    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        next_pc_d  = next_pc_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        latch_word = 1'b0;
        if (redirect) begin
            next_pc_d = redir_tgt;
            if (state_q == S_WAIT) begin
                // Squash the in-flight word and restart the wait at the target.
                wcnt_d = LAT;
            end else if (fetch_req) begin
                state_d = S_WAIT;
                wcnt_d  = LAT;
            end else begin
                state_d = S_IDLE;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (fetch_req) begin
                        state_d = S_WAIT;
                        wcnt_d  = LAT;
                    end
                end
                S_WAIT: begin
                    if (wcnt_q != 4'd0) begin
                        wcnt_d = wcnt_q - 4'd1;
                    end else begin
                        ir_d       = imem_data;
                        pc_d       = next_pc_q;
                        next_pc_d  = next_pc_q + 32'd4;
                        state_d    = S_HOLD;
                        latch_word = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (ir_ack) begin
                        if (fetch_req) begin
                            state_d = S_WAIT;
                            wcnt_d  = LAT;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and datapath registers; reset drops any in-flight fetch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            wcnt_q    <= 4'd0;
            next_pc_q <= RESET_PC;
            pc_q      <= RESET_PC;
            ir_q      <= 32'h0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            next_pc_q <= next_pc_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] fetch_cnt_q;

    assign stall_cnt = stall_cnt_q;
    assign fetch_cnt = fetch_cnt_q;

    // Saturating counters: every WAIT cycle is a stall, only latched words are fetches.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= 32'h0;
            fetch_cnt_q <= 32'h0;
        end else begin
            if (busy && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (latch_word && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: two instances (MEM_LAT 0 and 3) share one input
// stream; each is compared every cycle against a transaction-level model.
module tb_instr_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_req;
  logic        ir_ack;
  logic        redirect;
  logic        redirect_sel;
  logic [31:0] redirect_tgt;

  logic        ir_valid_w[2];
  logic        busy_w[2];
  logic [31:0] ir_w[2];
  logic [31:0] pc_w[2];
  logic [31:0] pc_plus4_w[2];
  logic [31:0] imem_addr_w[2];
  logic [31:0] imem_data_w[2];
  logic [1:0]  state_w[2];
`ifdef IFU_PERF_CNT_EN
  logic [31:0] stall_w[2];
  logic [31:0] fetch_w[2];
`endif

  int n_vec = 0;
  int n_err = 0;

  // Model state: fetch in progress with cycles remaining, or a held valid word.
  bit          m_fetching[2];
  bit          m_valid[2];
  int          m_left[2];
  logic [31:0] m_pc[2];
  logic [31:0] m_npc[2];
  logic [31:0] m_ir[2];
  logic [31:0] m_stall[2];
  logic [31:0] m_fetch[2];

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a == 32'h0000_00C0) return 32'h1400_FFF1;   // BNE, imm -15
    if (a == 32'h0000_0100) return 32'h0800_FFFF;   // JMP, imm -1
    return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  function automatic int lat_of(input int i);
    return (i == 0) ? 0 : 3;
  endfunction

  assign imem_data_w[0] = rom_word(imem_addr_w[0]);
  assign imem_data_w[1] = rom_word(imem_addr_w[1]);

  instr_fetch_unit #(.RESET_PC(RPC), .MEM_LAT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req),
    .ir_valid(ir_valid_w[0]), .ir(ir_w[0]), .pc(pc_w[0]), .pc_plus4(pc_plus4_w[0]),
    .ir_ack(ir_ack), .redirect(redirect), .redirect_sel(redirect_sel),
    .redirect_tgt(redirect_tgt), .imem_addr(imem_addr_w[0]), .imem_data(imem_data_w[0]),
`ifdef IFU_PERF_CNT_EN
    .stall_cnt(stall_w[0]), .fetch_cnt(fetch_w[0]),
`endif
    .busy(busy_w[0]), .state_dbg(state_w[0])
  );

  instr_fetch_unit #(.RESET_PC(RPC), .MEM_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req),
    .ir_valid(ir_valid_w[1]), .ir(ir_w[1]), .pc(pc_w[1]), .pc_plus4(pc_plus4_w[1]),
    .ir_ack(ir_ack), .redirect(redirect), .redirect_sel(redirect_sel),
    .redirect_tgt(redirect_tgt), .imem_addr(imem_addr_w[1]), .imem_data(imem_data_w[1]),
`ifdef IFU_PERF_CNT_EN
    .stall_cnt(stall_w[1]), .fetch_cnt(fetch_w[1]),
`endif
    .busy(busy_w[1]), .state_dbg(state_w[1])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      logic [31:0] t;
      logic [31:0] off;
      if (!rst_n) begin
        m_fetching[i] = 0;
        m_valid[i]    = 0;
        m_left[i]     = 0;
        m_pc[i]       = RPC;
        m_npc[i]      = RPC;
        m_ir[i]       = 32'h0;
        m_stall[i]    = 32'h0;
        m_fetch[i]    = 32'h0;
      end else begin
        if (m_fetching[i]) m_stall[i] = m_stall[i] + 1;
        if (redirect) begin
          off = {{16{m_ir[i][15]}}, m_ir[i][15:0]} * 32'd4;
          t = redirect_sel ? (redirect_tgt - (redirect_tgt % 32'd4)) : (m_pc[i] + 32'd4 + off);
          m_npc[i] = t;
          if (m_fetching[i]) begin
            m_left[i] = lat_of(i) + 1;
          end else begin
            m_valid[i] = 0;
            if (fetch_req) begin
              m_fetching[i] = 1;
              m_left[i]     = lat_of(i) + 1;
            end
          end
        end else if (m_fetching[i]) begin
          m_left[i]--;
          if (m_left[i] == 0) begin
            m_ir[i]       = rom_word(m_npc[i]);
            m_pc[i]       = m_npc[i];
            m_npc[i]      = m_npc[i] + 32'd4;
            m_valid[i]    = 1;
            m_fetching[i] = 0;
            m_fetch[i]    = m_fetch[i] + 1;
          end
        end else if (m_valid[i]) begin
          if (ir_ack) begin
            m_valid[i] = 0;
            if (fetch_req) begin
              m_fetching[i] = 1;
              m_left[i]     = lat_of(i) + 1;
            end
          end
        end else if (fetch_req) begin
          m_fetching[i] = 1;
          m_left[i]     = lat_of(i) + 1;
        end
      end
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("ir_valid%0d", i), {31'h0, ir_valid_w[i]}, {31'h0, m_valid[i]});
      check_eq($sformatf("busy%0d", i), {31'h0, busy_w[i]}, {31'h0, m_fetching[i]});
      check_eq($sformatf("ir%0d", i), ir_w[i], m_ir[i]);
      check_eq($sformatf("pc%0d", i), pc_w[i], m_pc[i]);
      check_eq($sformatf("pc_plus4_%0d", i), pc_plus4_w[i], m_pc[i] + 32'd4);
      check_eq($sformatf("imem_addr%0d", i), imem_addr_w[i], m_npc[i]);
`ifdef IFU_PERF_CNT_EN
      check_eq($sformatf("stall_cnt%0d", i), stall_w[i], m_stall[i]);
      check_eq($sformatf("fetch_cnt%0d", i), fetch_w[i], m_fetch[i]);
`endif
    end
  endtask

  // Drive one cycle of inputs, clock it, then compare #1 after the edge.
  task automatic cycle(input logic fr, input logic ack, input logic rd, input logic sel,
                       input logic [31:0] tgt, input logic rn);
    fetch_req    = fr;
    ir_ack       = ack;
    redirect     = rd;
    redirect_sel = sel;
    redirect_tgt = tgt;
    rst_n        = rn;
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0);   // reset overrides inputs
    check_eq("rst_addr", imem_addr_w[0], RPC);
    check_eq("rst_ir", ir_w[1], 32'h0);
    check_eq("rst_valid", {31'h0, ir_valid_w[1]}, 32'h0);
  endtask

  initial begin
    logic [31:0] exp_addr;
    int          nbusy0;
    int          nbusy1;
    fetch_req = 0; ir_ack = 0; redirect = 0; redirect_sel = 0; redirect_tgt = 0; rst_n = 0;

    // Sequential stream with fetch_req and ir_ack held high.
    do_reset();
    exp_addr = RPC;
    for (int k = 0; k < 24; k++) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      if (ir_valid_w[0]) begin
        check_eq("seq_pc", pc_w[0], exp_addr);
        check_eq("seq_ir", ir_w[0], rom_word(exp_addr));
        exp_addr = exp_addr + 32'd4;
      end
    end
    check_eq("seq_count", exp_addr, RPC + 32'd48);

    // Backward relative branch from 0xC0.
    do_reset();
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_00C0, 1'b1);
    idle(6);
    check_eq("bne_ir", ir_w[1], 32'h1400_FFF1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    check_eq("bne_tgt0", imem_addr_w[0], 32'h0000_0088);
    check_eq("bne_tgt1", imem_addr_w[1], 32'h0000_0088);
    check_eq("bne_valid", {31'h0, ir_valid_w[0]}, 32'h0);

    // Self-loop JMP at 0x100.
    do_reset();
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 1'b1);
    idle(6);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      idle(6);
      check_eq("loop_pc0", pc_w[0], 32'h0000_0100);
      check_eq("loop_pc1", pc_w[1], 32'h0000_0100);
    end

    // Wait-state length and redirect during WAIT.
    do_reset();
    nbusy0 = 0; nbusy1 = 0;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      nbusy0 += int'(busy_w[0]);
      nbusy1 += int'(busy_w[1]);
      if (k < 7) idle(1);
    end
    check_eq("busy_len0", nbusy0, 32'd1);
    check_eq("busy_len3", nbusy1, 32'd4);
    do_reset();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    idle(1);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0023, 1'b1);
    check_eq("squash_addr", imem_addr_w[1], 32'h0000_0020);
    nbusy1 = 0;
    for (int k = 0; k < 8; k++) begin
      nbusy1 += int'(busy_w[1]);
      idle(1);
    end
    check_eq("squash_busy", nbusy1, 32'd4);
    check_eq("squash_ir", ir_w[1], rom_word(32'h0000_0020));
    check_eq("squash_pc", pc_w[1], 32'h0000_0020);

    // Redirect beats ir_ack; reset during WAIT.
    do_reset();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    idle(5);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0040, 1'b1);
    check_eq("rd_ack_valid", {31'h0, ir_valid_w[1]}, 32'h0);
    idle(2);
    check_eq("rd_ack_addr", imem_addr_w[0], 32'h0000_0040);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    check_eq("wait_rst_ir", ir_w[1], 32'h0);
    check_eq("wait_rst_busy", {31'h0, busy_w[1]}, 32'h0);
    check_eq("wait_rst_addr", imem_addr_w[1], RPC);

    // Wrap at the top of the address space.
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
    idle(6);
    check_eq("wrap_next", imem_addr_w[1], 32'h0);

    // Randomized traffic.
    do_reset();
    for (int k = 0; k < 600; k++) begin
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0,
            $urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 49) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
